// File: rtl/pin_debouncer.sv
// -----------------------------------------------------------------------------
// pin_debouncer
//
// Conditions one raw device pin before it reaches the registered logic cells.
// The asynchronous pin goes through a two-flop synchroniser. A change in the
// synchronised value is accepted only after it has differed from the current
// debounced level on STABLE_CYCLES+1 consecutive clocks. Accepted changes update
// `level` and raise a one-clock `rise` or `fall` strobe on the same edge.
//
// Optional feature macro: PIN_DEBOUNCER_EDGE_COUNT_EN
//   When defined, an 8-bit wrapping counter of accepted edges is exported on
//   `edge_cnt`. When undefined, the port and the counter do not exist.
//
// The FSM state is exported on `debug_state` (0 = STABLE, 1 = SETTLING) so
// checkers can observe it without reaching into the hierarchy.
// -----------------------------------------------------------------------------
module pin_debouncer #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_WIDTH     = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin_in,
  output logic       level,
  output logic       rise,
  output logic       fall,
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
  output logic [7:0] edge_cnt,
`endif
  output logic       debug_state
);

  // Settle counter terminal value. The counter counts the extra clocks a new
  // value has persisted beyond the detecting clock, so it never passes this.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  logic                 s1;
  logic                 s2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-flop synchroniser; only s2 is consumed by the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // Debounce FSM: owns level, strobes and settle counter. Strobes default low
  // every clock so they can only ever be one cycle wide.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STABLE;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE: begin
          // A new synchronised value starts the settle window.
          if (s2 != level) begin
            state <= SETTLING;
            cnt   <= '0;
          end
        end
        SETTLING: begin
          if (s2 == level) begin
            // Value fell back before the window closed: glitch, drop it.
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Window complete: accept and strobe in the same edge.
            state <= STABLE;
            cnt   <= '0;
            level <= s2;
            rise  <= s2;
            fall  <= ~s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
  // Accepted-edge detector, evaluated on the same terms as the FSM acceptance
  // branch so the count moves on the edge the strobe is raised.
  logic accept;
  assign accept = !reset && (state == SETTLING) && (s2 != level) && (cnt == CNT_LAST);

  // Accepted-edge counter; wraps 255 -> 0 with no saturation.
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_cnt <= 8'd0;
    end else if (accept) begin
      edge_cnt <= edge_cnt + 8'd1;
    end
  end
`endif

  assign debug_state = state;

endmodule

// File: tb/tb_pin_debouncer.sv
// -----------------------------------------------------------------------------
// tb_pin_debouncer
//
// Bench for pin_debouncer at STABLE_CYCLES=4, RESET_LEVEL=0. The reference
// model keeps the pin's history as a delay line and accepts a change once the
// delayed pin has disagreed with the model level for STABLE_CYCLES+1 clocks in
// a row (a plain run-length count).
// -----------------------------------------------------------------------------
module tb_pin_debouncer;

  localparam int   SC = 4;
  localparam logic RL = 1'b0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pin_in = 1'b0;
  logic level, rise, fall, debug_state;
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
  logic [7:0] edge_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic hist[2];      // hist[0] = pin one clock ago, hist[1] = two clocks ago
  logic m_level;
  logic m_rise, m_fall;
  int   m_run;        // consecutive clocks the delayed pin disagreed with level
  logic [7:0] m_ecnt;

  pin_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_WIDTH(8),
    .RESET_LEVEL(RL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pin_in(pin_in),
    .level(level),
    .rise(rise),
    .fall(fall),
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
    .edge_cnt(edge_cnt),
`endif
    .debug_state(debug_state)
  );

  // Clock generation.
  always #5 clock = ~clock;

  // Driver: apply pin/reset, advance one clock, advance the model, then settle
  // 1 time unit past the edge so outputs are sampled away from it.
  task automatic step(input logic p, input logic r);
    logic delayed;
    pin_in = p;
    reset  = r;
    @(posedge clock);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      hist[0] = RL;
      hist[1] = RL;
      m_level = RL;
      m_run   = 0;
      m_ecnt  = 8'd0;
    end else begin
      delayed = hist[1];
      if (delayed != m_level) begin
        m_run = m_run + 1;
        if (m_run == SC + 1) begin
          m_level = delayed;
          m_rise  = delayed;
          m_fall  = !delayed;
          m_run   = 0;
          m_ecnt  = m_ecnt + 8'd1;
        end
      end else begin
        m_run = 0;
      end
      hist[1] = hist[0];
      hist[0] = p;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (level !== RL || rise !== 1'b0 || fall !== 1'b0 || debug_state !== 1'b0) begin
      errors++;
      $display("FAIL reset: level=%b rise=%b fall=%b state=%b, required level=%b rise=0 fall=0 state=0",
               level, rise, fall, debug_state, RL);
    end
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
    checks++;
    if (edge_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_edge_cnt: got %0d, required 0", edge_cnt);
    end
`endif
    step(1'b0, 1'b0);
  endtask

  // Clean 0->1: level must go high on the 7th posedge after the change.
  task automatic test_rise_latency();
    int first_hi;
    int rises;
    first_hi = -1;
    rises    = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (rise === 1'b1) rises++;
      if (level === 1'b1 && first_hi < 0) first_hi = i;
      checks++;
      if (level !== m_level || rise !== m_rise || fall !== m_fall) begin
        errors++;
        $display("FAIL rise_model[%0d]: level/rise/fall=%b%b%b, required %b%b%b",
                 i, level, rise, fall, m_level, m_rise, m_fall);
      end
    end
    checks++;
    if (first_hi !== SC + 2) begin
      errors++;
      $display("FAIL rise_latency: level high at posedge index %0d, required %0d", first_hi, SC + 2);
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL rise_count: %0d rise strobes, required 1", rises);
    end
  endtask

  // Clean 1->0: fall strobes once and level drops on the 7th posedge.
  task automatic test_fall_latency();
    int first_lo;
    int falls;
    first_lo = -1;
    falls    = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      if (fall === 1'b1) falls++;
      if (level === 1'b0 && first_lo < 0) first_lo = i;
      checks++;
      if (level !== m_level || rise !== m_rise || fall !== m_fall) begin
        errors++;
        $display("FAIL fall_model[%0d]: level/rise/fall=%b%b%b, required %b%b%b",
                 i, level, rise, fall, m_level, m_rise, m_fall);
      end
    end
    checks++;
    if (first_lo !== SC + 2) begin
      errors++;
      $display("FAIL fall_latency: level low at posedge index %0d, required %0d", first_lo, SC + 2);
    end
    checks++;
    if (falls !== 1) begin
      errors++;
      $display("FAIL fall_count: %0d fall strobes, required 1", falls);
    end
  endtask

  // Pulse of `width` clocks from a settled low level; counts rise strobes.
  task automatic test_glitch(input int width, input int exp_rises);
    int rises;
    rises = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < width + 12; i++) begin
      step((i < width) ? 1'b1 : 1'b0, 1'b0);
      if (rise === 1'b1) rises++;
      checks++;
      if (level !== m_level || rise !== m_rise || fall !== m_fall || debug_state !== (m_run != 0)) begin
        errors++;
        $display("FAIL glitch%0d_model[%0d]: level/rise/fall/state=%b%b%b%b, required %b%b%b%b",
                 width, i, level, rise, fall, debug_state, m_level, m_rise, m_fall, m_run != 0);
      end
    end
    checks++;
    if (rises !== exp_rises) begin
      errors++;
      $display("FAIL glitch%0d_rises: %0d rise strobes, required %0d", width, rises, exp_rises);
    end
  endtask

  // Reset lands 3 clocks into settling: change abandoned, then re-accepted.
  task automatic test_reset_mid_settle();
    int first_hi;
    int rises;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    checks++;
    if (debug_state !== 1'b1 || level !== 1'b0) begin
      errors++;
      $display("FAIL mid_settle_pre: state=%b level=%b, required state=1 level=0", debug_state, level);
    end
    rises = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      if (rise === 1'b1) rises++;
    end
    checks++;
    if (level !== 1'b0 || rises !== 0 || debug_state !== 1'b0) begin
      errors++;
      $display("FAIL mid_settle_reset: level=%b rises=%0d state=%b, required level=0 rises=0 state=0",
               level, rises, debug_state);
    end
    first_hi = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (level === 1'b1 && first_hi < 0) first_hi = i;
    end
    checks++;
    if (first_hi !== SC + 2) begin
      errors++;
      $display("FAIL mid_settle_release: level high at index %0d, required %0d", first_hi, SC + 2);
    end
  endtask

  // Random hold lengths around the acceptance threshold plus sparse resets.
  task automatic test_random();
    logic p;
    int   hold;
    int   n;
    p = 1'b0;
    n = 0;
    while (n < 3000) begin
      hold = $urandom_range(1, 9);
      p    = ~p;
      for (int k = 0; k < hold; k++) begin
        step(p, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        n++;
        checks++;
        if (level !== m_level || rise !== m_rise || fall !== m_fall || debug_state !== (m_run != 0)) begin
          errors++;
          $display("FAIL random[%0d]: level/rise/fall/state=%b%b%b%b, required %b%b%b%b",
                   n, level, rise, fall, debug_state, m_level, m_rise, m_fall, m_run != 0);
        end
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
        checks++;
        if (edge_cnt !== m_ecnt) begin
          errors++;
          $display("FAIL random_edge_cnt[%0d]: got %0d, required %0d", n, edge_cnt, m_ecnt);
        end
`endif
      end
    end
  endtask

`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
  // 256 accepted edges bring the counter back to its start; glitches don't move it.
  task automatic test_edge_count();
    logic [7:0] start;
    logic p;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    start = edge_cnt;
    p = 1'b0;
    for (int e = 0; e < 256; e++) begin
      p = ~p;
      for (int k = 0; k < SC + 4; k++) step(p, 1'b0);
    end
    checks++;
    if (edge_cnt !== start) begin
      errors++;
      $display("FAIL edge_cnt_wrap: got %0d, required %0d", edge_cnt, start);
    end
    for (int g = 0; g < 8; g++) begin
      step(~p, 1'b0);
      step(~p, 1'b0);
      for (int k = 0; k < 6; k++) step(p, 1'b0);
    end
    checks++;
    if (edge_cnt !== start) begin
      errors++;
      $display("FAIL edge_cnt_glitch: got %0d, required %0d", edge_cnt, start);
    end
  endtask
`endif

  initial begin
    hist[0] = RL;
    hist[1] = RL;
    m_level = RL;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_run   = 0;
    m_ecnt  = 8'd0;
    #1;
    test_reset();
    test_rise_latency();
    test_fall_latency();
    test_glitch(SC, 0);
    test_glitch(SC + 1, 1);
    test_reset_mid_settle();
    test_random();
`ifdef PIN_DEBOUNCER_EDGE_COUNT_EN
    test_edge_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
